// File: rtl/brg_hb_freeze_sender.sv
// Sweeps a freeze/unfreeze store to every compute tile (rows 2..num_tiles_y_p-1),
// throttled by a credit counter, then waits for all responses before pulsing done.
module brg_hb_freeze_sender #(
  parameter int              x_cord_width_p    = 4,
  parameter int              y_cord_width_p    = 4,
  parameter int              data_width_p      = 32,
  parameter int              addr_width_p      = 32,
  parameter int              num_tiles_x_p     = 4,
  parameter int              num_tiles_y_p     = 4,
  parameter int              max_out_credits_p = 16,
  parameter longint unsigned freeze_epa_p      = 'h0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      cmd_v_i,
  input  logic                      cmd_freeze_i,
  output logic                      cmd_ready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic                      out_v_o,
  input  logic                      out_ready_i,
  output logic [x_cord_width_p-1:0] out_x_o,
  output logic [y_cord_width_p-1:0] out_y_o,
  output logic [addr_width_p-1:0]   out_addr_o,
  output logic [data_width_p-1:0]   out_data_o,
  output logic [x_cord_width_p-1:0] out_src_x_o,
  output logic [y_cord_width_p-1:0] out_src_y_o,
  input  logic                      returned_v_i
);

  localparam int OCW = $clog2(max_out_credits_p + 1);
  localparam logic [x_cord_width_p-1:0] X_LAST  = x_cord_width_p'(num_tiles_x_p - 1);
  localparam logic [y_cord_width_p-1:0] Y_FIRST = y_cord_width_p'(2);
  localparam logic [y_cord_width_p-1:0] Y_LAST  = y_cord_width_p'(num_tiles_y_p - 1);
  localparam logic [OCW-1:0]            OC_MAX  = OCW'(max_out_credits_p);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [x_cord_width_p-1:0] x_cnt_q, x_cnt_d;
  logic [y_cord_width_p-1:0] y_cnt_q, y_cnt_d;
  logic                      freeze_q, freeze_d;
  logic [OCW-1:0]            outstanding_q, outstanding_d;
  logic                      error_q, error_d;
  logic                      send_v;
  logic                      xfer;

  // Outputs are forced to their idle values while reset is held, not just after it.
  always_comb begin
    send_v      = (state_q == SEND) && (outstanding_q < OC_MAX);
    out_v_o     = send_v && !reset_i;
    xfer        = out_v_o && out_ready_i;
    cmd_ready_o = reset_i || (state_q == IDLE);
    busy_o      = !reset_i && ((state_q == SEND) || (state_q == DRAIN));
    done_o      = !reset_i && (state_q == DONE);
    error_o     = error_q;
    out_x_o     = x_cnt_q;
    out_y_o     = y_cnt_q;
    out_addr_o  = addr_width_p'(freeze_epa_p);
    out_data_o  = {{(data_width_p-1){1'b0}}, freeze_q};
    out_src_x_o = my_x_i;
    out_src_y_o = my_y_i;
  end

  always_comb begin
    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    freeze_d      = freeze_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;

    case (state_q)
      IDLE: begin
        if (cmd_v_i) begin
          freeze_d = cmd_freeze_i;
          x_cnt_d  = '0;
          y_cnt_d  = Y_FIRST;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + 1'b1;
            if (y_cnt_q == Y_LAST) state_d = DRAIN;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A response with nothing outstanding is a protocol error; the count saturates at zero.
    if (xfer && !returned_v_i) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!xfer && returned_v_i) begin
      if (outstanding_q == '0) error_d = 1'b1;
      else                     outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      x_cnt_q       <= '0;
      y_cnt_q       <= Y_FIRST;
      freeze_q      <= 1'b0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      freeze_q      <= freeze_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

endmodule

// File: tb/tb_brg_hb_freeze_sender.sv
// Scoreboard bench: two instances (16 and 2 credits), each with its own monitor,
// response generator and expected-request queue filled when a command is accepted.
module tb_brg_hb_freeze_sender;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NX = 4;
  localparam int NY = 4;
  localparam int NT = NX * (NY - 2);
  localparam logic [AW-1:0] EPA  = 32'h0000_0c40;
  localparam logic [XW-1:0] MY_X = 4'd5;
  localparam logic [YW-1:0] MY_Y = 4'd1;

  typedef enum int {M_IDLE, M_SEND, M_DRAIN, M_DONE} mst_e;
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
  } req_t;

  // Hand-derived sweep order for a 4x4 mesh: rows 2 and 3, columns 0..3.
  logic [XW-1:0] EXP_X [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
  logic [YW-1:0] EXP_Y [8] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};

  logic clk = 1'b0;
  logic rst     [2];
  logic cmd_v   [2];
  logic cmd_frz [2];
  logic oready  [2];
  logic inj     [2];
  int   dly     [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MAXC = (g == 0) ? 16 : 2;
    logic          out_v, cmd_ready, busy, done, error;
    logic          ret = 1'b0;
    logic [XW-1:0] out_x, out_src_x;
    logic [YW-1:0] out_y, out_src_y;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    mst_e          mst   = M_IDLE;
    int            os    = 0;
    int            nerr  = 0;
    int            nchk  = 0;
    int            ntx   = 0;
    int            ndone = 0;
    logic          err_m = 1'b0;
    logic [7:0]    dl    = '0;
    req_t          q[$];

    brg_hb_freeze_sender #(
      .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
      .num_tiles_x_p(NX), .num_tiles_y_p(NY), .max_out_credits_p(MAXC),
      .freeze_epa_p(64'(EPA))
    ) u_dut (
      .clk_i(clk), .reset_i(rst[g]), .my_x_i(MY_X), .my_y_i(MY_Y),
      .cmd_v_i(cmd_v[g]), .cmd_freeze_i(cmd_frz[g]), .cmd_ready_o(cmd_ready),
      .busy_o(busy), .done_o(done), .error_o(error),
      .out_v_o(out_v), .out_ready_i(oready[g]), .out_x_o(out_x), .out_y_o(out_y),
      .out_addr_o(out_addr), .out_data_o(out_data), .out_src_x_o(out_src_x),
      .out_src_y_o(out_src_y), .returned_v_i(ret)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL dut%0d %s: got %b expected %b at %0t", g, nm, act, exp, $time);
      end
    endtask

    task automatic chkw(input string nm, input logic [79:0] act, input logic [79:0] exp);
      nchk++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL dut%0d %s: got %h expected %h at %0t", g, nm, act, exp, $time);
      end
    endtask

    always @(negedge clk) begin
      logic xfer;
      logic exp_v;
      int   os_now;
      ret   = ((dly[g] > 0) ? dl[dly[g]-1] : 1'b0) || inj[g];
      exp_v = !rst[g] && (mst == M_SEND) && (os < MAXC);
      chk1("out_v", out_v, exp_v);
      chk1("busy", busy, !rst[g] && ((mst == M_SEND) || (mst == M_DRAIN)));
      chk1("done", done, !rst[g] && (mst == M_DONE));
      chk1("cmd_ready", cmd_ready, rst[g] || (mst == M_IDLE));
      chk1("error", error, err_m);
      if (exp_v && q.size() > 0)
        chkw("req_fields", {out_x, out_y, out_addr, out_data, out_src_x, out_src_y},
             {q[0].x, q[0].y, EPA, q[0].d, MY_X, MY_Y});
      xfer   = exp_v && oready[g];
      os_now = os;
      if (done) ndone++;
      if (rst[g]) begin
        mst   = M_IDLE;
        os    = 0;
        err_m = 1'b0;
        q.delete();
        dl    = '0;
      end else begin
        if (xfer) begin
          ntx++;
          void'(q.pop_front());
        end
        if (xfer && !ret) os++;
        else if (ret && !xfer) begin
          if (os == 0) err_m = 1'b1;
          else         os--;
        end
        case (mst)
          M_IDLE: begin
            if (cmd_v[g]) begin
              mst = M_SEND;
              for (int i = 0; i < NT; i++)
                q.push_back('{x: EXP_X[i], y: EXP_Y[i], d: DW'(cmd_frz[g])});
            end
          end
          M_SEND:  if (xfer && q.size() == 0) mst = M_DRAIN;
          M_DRAIN: if (os_now == 0) mst = M_DONE;
          default: mst = M_IDLE;
        endcase
        dl = {dl[6:0], xfer};
      end
    end
  end

  int terr = 0;
  int tchk = 0;

  task automatic tcheck(input string nm, input int act, input int exp);
    tchk++;
    if (act != exp) begin
      terr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int get_ndone(input int i);
    return (i == 0) ? g_dut[0].ndone : g_dut[1].ndone;
  endfunction

  function automatic int get_ntx(input int i);
    return (i == 0) ? g_dut[0].ntx : g_dut[1].ntx;
  endfunction

  task automatic wait_done(input int i, input int budget);
    int start;
    bit seen;
    start = get_ndone(i);
    seen  = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc(1);
      if (get_ndone(i) != start) seen = 1'b1;
    end
    tcheck("sweep_done_within_budget", int'(seen), 1);
    cyc(2);
  endtask

  task automatic issue(input int i, input logic frz);
    cmd_v[i]   = 1'b1;
    cmd_frz[i] = frz;
    cyc(1);
    cmd_v[i]   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, dn0;
    rst     = '{1'b1, 1'b1};
    cmd_v   = '{1'b0, 1'b0};
    cmd_frz = '{1'b0, 1'b0};
    oready  = '{1'b1, 1'b1};
    inj     = '{1'b0, 1'b0};
    dly     = '{2, 6};
    cyc(3);
    rst = '{1'b0, 1'b0};
    cyc(2);

    // Full freeze sweep, responses two cycles after each send.
    tx0 = get_ntx(0); dn0 = get_ndone(0);
    issue(0, 1'b1);
    wait_done(0, 60);
    tcheck("t1_transfers", get_ntx(0) - tx0, 8);
    tcheck("t1_done_pulses", get_ndone(0) - dn0, 1);

    // Two-credit instance: stalls at two outstanding, resumes after first response.
    tx0 = get_ntx(1); dn0 = get_ndone(1);
    issue(1, 1'b1);
    cyc(4);
    @(negedge clk);
    tcheck("t2_stalled_out_v", int'(g_dut[1].out_v), 0);
    cyc(3);
    @(negedge clk);
    tcheck("t2_resumed_out_v", int'(g_dut[1].out_v), 1);
    wait_done(1, 120);
    tcheck("t2_transfers", get_ntx(1) - tx0, 8);
    tcheck("t2_done_pulses", get_ndone(1) - dn0, 1);

    // Backpressure on the first request for three cycles.
    tx0 = get_ntx(0); dn0 = get_ndone(0);
    oready[0] = 1'b0;
    issue(0, 1'b1);
    cyc(1);
    @(negedge clk);
    tcheck("t3_held_out_v", int'(g_dut[0].out_v), 1);
    tcheck("t3_held_x", int'(g_dut[0].out_x), 0);
    tcheck("t3_held_y", int'(g_dut[0].out_y), 2);
    tcheck("t3_no_transfer_yet", get_ntx(0) - tx0, 0);
    cyc(2);
    oready[0] = 1'b1;
    wait_done(0, 60);
    tcheck("t3_transfers", get_ntx(0) - tx0, 8);
    tcheck("t3_done_pulses", get_ndone(0) - dn0, 1);

    // Same-cycle send and response hold the count at one; stray response sets error.
    dly[0] = 1;
    issue(0, 1'b1);
    cyc(3);
    @(negedge clk);
    tcheck("t4_outstanding_one", int'(g_dut[0].u_dut.outstanding_q), 1);
    wait_done(0, 60);
    inj[0] = 1'b1;
    cyc(1);
    inj[0] = 1'b0;
    cyc(3);
    @(negedge clk);
    tcheck("t4_error_sticky", int'(g_dut[0].error), 1);
    dly[0] = 2;
    cyc(1);

    // Unfreeze sweep abandoned by reset after the third transfer, then restarted.
    tx0 = get_ntx(0); dn0 = get_ndone(0);
    issue(0, 1'b0);
    cyc(3);
    rst[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0;
    @(negedge clk);
    tcheck("t5_out_v_after_reset", int'(g_dut[0].out_v), 0);
    tcheck("t5_done_after_reset", int'(g_dut[0].done), 0);
    tcheck("t5_cmd_ready_after_reset", int'(g_dut[0].cmd_ready), 1);
    tcheck("t5_error_cleared", int'(g_dut[0].error), 0);
    tcheck("t5_transfers_before_reset", get_ntx(0) - tx0, 3);
    cyc(2);
    issue(0, 1'b0);
    wait_done(0, 60);
    tcheck("t5_transfers_total", get_ntx(0) - tx0, 11);
    tcheck("t5_done_pulses", get_ndone(0) - dn0, 1);

    // A command pulse during SEND must not start a second sweep.
    tx0 = get_ntx(0); dn0 = get_ndone(0);
    issue(0, 1'b1);
    cyc(2);
    cmd_v[0] = 1'b1;
    cyc(1);
    cmd_v[0] = 1'b0;
    wait_done(0, 60);
    cyc(12);
    tcheck("t6_transfers", get_ntx(0) - tx0, 8);
    tcheck("t6_done_pulses", get_ndone(0) - dn0, 1);
    tcheck("t6_dut1_idle_transfers", get_ntx(1), 8);

    $display("Result: errors=%0d of %0d checks",
             terr + g_dut[0].nerr + g_dut[1].nerr,
             tchk + g_dut[0].nchk + g_dut[1].nchk);
    $finish;
  end

endmodule
